// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
//
// Takes the EX/MEM pipeline register outputs, issues a request/acknowledge
// data-memory access for loads and stores, steers store byte lanes, extracts
// and extends load data, stalls upstream while an access is outstanding, and
// registers the write-back result into the MEM/WB boundary.
//
// Optional build macro: MEM_ALIGN_CHECK_EN
//   defined   -> misaligned lw/sw is a fault: no access, no write-back, Wb_err set
//   undefined -> word accesses ignore the low two address bits
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   Mem_*                 EX/MEM register outputs (address, store data, link
//                         value, destination, control, overflow)
//   dm_req/we/addr/be/wdata  registered memory request
//   dm_rdata, dm_ack      memory read data and one-cycle completion
//   Mem_stall             combinational upstream freeze
//   Wb_Rw/RegWr/busW      MEM/WB register-file write port
//   Wb_err                sticky timeout / fault flag
//
// State table:
//   IDLE | no access outstanding; launches a request when one is present
//   BUSY | request outstanding; waiting for dm_ack or the timeout

module mem_access_unit #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Mem_ALUres,
  input  logic [31:0] Mem_busB,
  input  logic [31:0] Mem_pcadd4,
  input  logic [4:0]  Mem_Rw,
  input  logic        Mem_RegWr,
  input  logic        Mem_MemWr,
  input  logic [1:0]  Mem_MemtoReg,
  input  logic [1:0]  Mem_lbyte,
  input  logic        Mem_sbyte,
  input  logic        Mem_Overflow,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        Mem_stall,
  output logic [4:0]  Wb_Rw,
  output logic        Wb_RegWr,
  output logic [31:0] Wb_busW,
  output logic        Wb_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TC = 8'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        acc, fault, go, ack_ok, timeout_hit;
  logic [7:0]  ld_byte;
  logic [31:0] load_data, wb_data;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  assign acc = !Mem_Overflow && (Mem_MemWr || Mem_MemtoReg == 2'b01);

`ifdef MEM_ALIGN_CHECK_EN
  // Only full-word accesses care about alignment; byte accesses never fault.
  always_comb begin
    fault = 1'b0;
    if (acc && state_q == IDLE && Mem_ALUres[1:0] != 2'b00) begin
      if (Mem_MemWr)
        fault = !Mem_sbyte;
      else
        fault = (Mem_lbyte == 2'b00) || (Mem_lbyte == 2'b11);
    end
  end
`else
  assign fault = 1'b0;
`endif

  assign go          = acc && !fault;
  assign ack_ok      = (state_q == BUSY) && dm_ack;
  assign timeout_hit = (state_q == BUSY) && !dm_ack && (cnt_q == TC);
  assign Mem_stall   = ((state_q == IDLE) && go) ||
                       ((state_q == BUSY) && !dm_ack && !timeout_hit);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = BUSY;
      BUSY:    if (ack_ok || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = Mem_busB;
    if (Mem_MemWr && Mem_sbyte) begin
      be_d    = 4'b0001 << Mem_ALUres[1:0];
      wdata_d = {4{Mem_busB[7:0]}};
    end
  end

  always_comb begin
    ld_byte = dm_rdata[7:0];
    case (Mem_ALUres[1:0])
      2'd0:    ld_byte = dm_rdata[7:0];
      2'd1:    ld_byte = dm_rdata[15:8];
      2'd2:    ld_byte = dm_rdata[23:16];
      default: ld_byte = dm_rdata[31:24];
    endcase
  end

  // A timed-out access completes with zero load data.
  always_comb begin
    load_data = 32'h0;
    if (ack_ok) begin
      case (Mem_lbyte)
        2'b01:   load_data = {{24{ld_byte[7]}}, ld_byte};
        2'b10:   load_data = {24'h0, ld_byte};
        default: load_data = dm_rdata;
      endcase
    end
  end

  always_comb begin
    wb_data = Mem_ALUres;
    case (Mem_MemtoReg)
      2'b01:   wb_data = load_data;
      2'b10:   wb_data = Mem_pcadd4;
      default: wb_data = Mem_ALUres;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= 32'h0;
      dm_be    <= 4'h0;
      dm_wdata <= 32'h0;
      Wb_Rw    <= 5'd0;
      Wb_RegWr <= 1'b0;
      Wb_busW  <= 32'h0;
      Wb_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (go) begin
            dm_req   <= 1'b1;
            dm_we    <= Mem_MemWr;
            dm_addr  <= {Mem_ALUres[31:2], 2'b00};
            dm_be    <= be_d;
            dm_wdata <= wdata_d;
            cnt_q    <= 8'd0;
          end
        end
        BUSY: begin
          if (ack_ok || timeout_hit) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase

      if (timeout_hit || fault)
        Wb_err <= 1'b1;

      // Stalled edges insert a bubble; destination and data hold.
      if (!Mem_stall) begin
        Wb_Rw    <= Mem_Rw;
        Wb_RegWr <= Mem_RegWr && !Mem_Overflow && !fault;
        Wb_busW  <= wb_data;
      end else begin
        Wb_RegWr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Mem_ALUres, Mem_busB, Mem_pcadd4;
  logic [4:0]  Mem_Rw;
  logic        Mem_RegWr, Mem_MemWr;
  logic [1:0]  Mem_MemtoReg, Mem_lbyte;
  logic        Mem_sbyte, Mem_Overflow;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic        Mem_stall;
  logic [4:0]  Wb_Rw;
  logic        Wb_RegWr;
  logic [31:0] Wb_busW;
  logic        Wb_err;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .Mem_ALUres(Mem_ALUres), .Mem_busB(Mem_busB), .Mem_pcadd4(Mem_pcadd4),
    .Mem_Rw(Mem_Rw), .Mem_RegWr(Mem_RegWr), .Mem_MemWr(Mem_MemWr),
    .Mem_MemtoReg(Mem_MemtoReg), .Mem_lbyte(Mem_lbyte), .Mem_sbyte(Mem_sbyte),
    .Mem_Overflow(Mem_Overflow),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .Mem_stall(Mem_stall),
    .Wb_Rw(Wb_Rw), .Wb_RegWr(Wb_RegWr), .Wb_busW(Wb_busW), .Wb_err(Wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    Mem_ALUres   = 32'h0;
    Mem_busB     = 32'h0;
    Mem_pcadd4   = 32'h0;
    Mem_Rw       = 5'd0;
    Mem_RegWr    = 1'b0;
    Mem_MemWr    = 1'b0;
    Mem_MemtoReg = 2'b00;
    Mem_lbyte    = 2'b00;
    Mem_sbyte    = 1'b0;
    Mem_Overflow = 1'b0;
    dm_ack       = 1'b0;
    dm_rdata     = 32'h0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] lb, input logic [4:0] rw);
    bubble();
    Mem_ALUres   = a;
    Mem_lbyte    = lb;
    Mem_MemtoReg = 2'b01;
    Mem_RegWr    = 1'b1;
    Mem_Rw       = rw;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic sb);
    bubble();
    Mem_ALUres = a;
    Mem_busB   = d;
    Mem_MemWr  = 1'b1;
    Mem_sbyte  = sb;
  endtask

  initial begin
    bubble();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_req",    32'(dm_req),    32'h0);
    chk("rst_stall",  32'(Mem_stall), 32'h0);
    chk("rst_busW",   Wb_busW,        32'h0);
    chk("rst_err",    32'(Wb_err),    32'h0);

    // ALU op, then a load interrupted by reset mid-BUSY
    bubble();
    Mem_ALUres = 32'h1234; Mem_RegWr = 1'b1; Mem_Rw = 5'd9;
    tick();
    chk("alu_busW", Wb_busW, 32'h1234);
    load(32'h8, 2'b00, 5'd3);
    tick();
    chk("midrst_req_before", 32'(dm_req), 32'h1);
    rst = 1'b1;
    tick();
    chk("midrst_req",   32'(dm_req),   32'h0);
    chk("midrst_Rw",    32'(Wb_Rw),    32'h0);
    chk("midrst_RegWr", 32'(Wb_RegWr), 32'h0);
    chk("midrst_busW",  Wb_busW,       32'h0);
    rst = 1'b0;
    bubble();
    dm_ack = 1'b1; dm_rdata = 32'hCAFEF00D;
    #1;
    chk("late_ack_stall", 32'(Mem_stall), 32'h0);
    tick();
    dm_ack = 1'b0;
    chk("late_ack_req",   32'(dm_req),   32'h0);
    chk("late_ack_RegWr", 32'(Wb_RegWr), 32'h0);
    chk("late_ack_busW",  Wb_busW,       32'h0);

    // sw, zero-wait ack
    store(32'h10, 32'hDEADBEEF, 1'b0);
    #1;
    chk("sw_stall_idle", 32'(Mem_stall), 32'h1);
    tick();
    dm_ack = 1'b1;
    #1;
    chk("sw_req",   32'(dm_req),    32'h1);
    chk("sw_we",    32'(dm_we),     32'h1);
    chk("sw_addr",  dm_addr,        32'h10);
    chk("sw_be",    32'(dm_be),     32'hF);
    chk("sw_wdata", dm_wdata,       32'hDEADBEEF);
    chk("sw_stall_ack", 32'(Mem_stall), 32'h0);
    tick();
    bubble();
    #1;
    chk("sw_req_drop", 32'(dm_req),   32'h0);
    chk("sw_RegWr",    32'(Wb_RegWr), 32'h0);
    chk("sw_stall_after", 32'(Mem_stall), 32'h0);

    // sb at byte 3
    store(32'h13, 32'h000000A5, 1'b1);
    tick();
    dm_ack = 1'b1;
    #1;
    chk("sb_addr",  dm_addr,     32'h10);
    chk("sb_be",    32'(dm_be),  32'h8);
    chk("sb_wdata", dm_wdata,    32'hA5A5A5A5);
    tick();
    bubble();

    // lb, ack on the fourth BUSY cycle
    load(32'h21, 2'b01, 5'd5);
    #1;
    chk("lb_stall_c1", 32'(Mem_stall), 32'h1);
    tick();
    chk("lb_we",    32'(dm_we),  32'h0);
    chk("lb_be",    32'(dm_be),  32'hF);
    chk("lb_addr",  dm_addr,     32'h20);
    chk("lb_stall_c2", 32'(Mem_stall), 32'h1);
    tick();
    chk("lb_stall_c3", 32'(Mem_stall), 32'h1);
    tick();
    chk("lb_stall_c4", 32'(Mem_stall), 32'h1);
    chk("lb_RegWr_bubble", 32'(Wb_RegWr), 32'h0);
    tick();
    dm_ack = 1'b1; dm_rdata = 32'h0000F000;
    #1;
    chk("lb_stall_ack", 32'(Mem_stall), 32'h0);
    tick();
    bubble();
    #1;
    chk("lb_busW",  Wb_busW,        32'hFFFFFFF0);
    chk("lb_RegWr", 32'(Wb_RegWr),  32'h1);
    chk("lb_Rw",    32'(Wb_Rw),     32'h5);
    chk("lb_req_drop", 32'(dm_req), 32'h0);

    // lbu, zero-wait
    load(32'h21, 2'b10, 5'd6);
    tick();
    dm_ack = 1'b1; dm_rdata = 32'h0000F000;
    tick();
    bubble();
    #1;
    chk("lbu_busW", Wb_busW,     32'h000000F0);
    chk("lbu_Rw",   32'(Wb_Rw),  32'h6);

    // lw
    load(32'h44, 2'b00, 5'd7);
    tick();
    dm_ack = 1'b1; dm_rdata = 32'h89ABCDEF;
    tick();
    bubble();
    #1;
    chk("lw_busW", Wb_busW, 32'h89ABCDEF);

    // overflowing store
    store(32'h50, 32'h11111111, 1'b0);
    Mem_Overflow = 1'b1; Mem_RegWr = 1'b1;
    #1;
    chk("ovf_stall", 32'(Mem_stall), 32'h0);
    tick();
    chk("ovf_req",   32'(dm_req),   32'h0);
    chk("ovf_RegWr", 32'(Wb_RegWr), 32'h0);

    // jal-style link
    bubble();
    Mem_MemtoReg = 2'b10; Mem_pcadd4 = 32'h3008; Mem_RegWr = 1'b1; Mem_Rw = 5'd31;
    #1;
    chk("jal_stall", 32'(Mem_stall), 32'h0);
    tick();
    chk("jal_busW",  Wb_busW,       32'h3008);
    chk("jal_RegWr", 32'(Wb_RegWr), 32'h1);
    chk("err_clear_before_timeout", 32'(Wb_err), 32'h0);

    // load timeout with ACK_TIMEOUT=4
    load(32'h60, 2'b00, 5'd8);
    tick();
    chk("to_req_1", 32'(dm_req), 32'h1);
    tick();
    chk("to_req_2", 32'(dm_req), 32'h1);
    tick();
    chk("to_req_3", 32'(dm_req), 32'h1);
    chk("to_stall_3", 32'(Mem_stall), 32'h1);
    tick();
    chk("to_req_4", 32'(dm_req), 32'h1);
    chk("to_stall_4", 32'(Mem_stall), 32'h0);
    tick();
    bubble();
    #1;
    chk("to_req_drop", 32'(dm_req),    32'h0);
    chk("to_err",      32'(Wb_err),    32'h1);
    chk("to_busW",     Wb_busW,        32'h0);
    chk("to_released", 32'(Mem_stall), 32'h0);

    // misaligned sw
    store(32'h72, 32'h55AA55AA, 1'b0);
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_stall", 32'(Mem_stall), 32'h0);
    tick();
    bubble();
    #1;
    chk("mis_req",   32'(dm_req),   32'h0);
    chk("mis_RegWr", 32'(Wb_RegWr), 32'h0);
    chk("mis_err",   32'(Wb_err),   32'h1);
`else
    chk("mis_stall", 32'(Mem_stall), 32'h1);
    tick();
    dm_ack = 1'b1;
    #1;
    chk("mis_req",  32'(dm_req), 32'h1);
    chk("mis_addr", dm_addr,     32'h70);
    chk("mis_be",   32'(dm_be),  32'hF);
    tick();
    bubble();
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
